// File: rtl/pong_pixel_compositor_if.sv
// Pixel-stream, game-state and video-output bundle for the Pong compositor.
// master drives pixel position and object state; slave returns RGB and collision flags.
interface pong_pixel_compositor_if #(
  parameter int NUM_PADDLES = 2,
  parameter int COLOR_W     = 10
);
  logic [9:0]               x;
  logic [9:0]               y;
  logic                     blank;
  logic                     frame_start;
  logic [9:0]               ball_x;
  logic [9:0]               ball_y;
  logic [10*NUM_PADDLES-1:0] paddle_x;
  logic [10*NUM_PADDLES-1:0] paddle_y;
  logic                     point_pulse;
  logic [COLOR_W-1:0]       vga_r;
  logic [COLOR_W-1:0]       vga_g;
  logic [COLOR_W-1:0]       vga_b;
  logic                     vga_blank_n;
  logic [NUM_PADDLES-1:0]   collision;
  logic                     collision_valid;

  modport master (
    output x, y, blank, frame_start, ball_x, ball_y, paddle_x, paddle_y, point_pulse,
    input  vga_r, vga_g, vga_b, vga_blank_n, collision, collision_valid
  );

  modport slave (
    input  x, y, blank, frame_start, ball_x, ball_y, paddle_x, paddle_y, point_pulse,
    output vga_r, vga_g, vga_b, vga_blank_n, collision, collision_valid
  );
endinterface

// File: rtl/pong_pixel_compositor.sv
// Renders ball, paddles and flashing midline from per-frame shadow registers.
// Fixed 2-cycle pixel latency, one pixel per clock, never stalls.
module pong_pixel_compositor #(
  parameter int NUM_PADDLES  = 2,
  parameter int PADDLE_W     = 10,
  parameter int PADDLE_H     = 100,
  parameter int BALL_SIZE    = 5,
  parameter int MID_LINE_X   = 325,
  parameter int MID_Y_LO     = 5,
  parameter int MID_Y_HI     = 470,
  parameter int MID_DASH     = 8,
  parameter int DISP_SHIFT   = 50,
  parameter int FLASH_FRAMES = 60,
  parameter int COLOR_W      = 10
) (
  input logic                    clk25,
  input logic                    reset_n,
  pong_pixel_compositor_if.slave vid
);

  localparam int DASH_DIV = (MID_DASH == 0) ? 1 : MID_DASH;
  localparam int FLASH_W  = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

  // 12-bit signed leaves headroom so neither negative screen y nor ox+W past 1023 wraps
  typedef logic signed [11:0] coord_t;

  function automatic logic in_span(input coord_t p, input coord_t lo, input int len);
    return (p >= lo) && (p < lo + coord_t'(len));
  endfunction

  logic [9:0]                sh_ball_x, sh_ball_y;
  logic [10*NUM_PADDLES-1:0] sh_pad_x, sh_pad_y;
  logic                      shadow_valid;

  logic [FLASH_W-1:0]        flash_cnt;
  logic [3:0]                frame_ctr;

  logic                      hit_ball, hit_mid, dash_row;
  logic [NUM_PADDLES-1:0]    hit_pad;
  logic                      hit_ball_s1, hit_mid_s1, blank_s1;
  logic [NUM_PADDLES-1:0]    hit_pad_s1;
  logic [NUM_PADDLES-1:0]    sticky;

  logic                      mid_red;
  logic [COLOR_W-1:0]        r_nx, g_nx, b_nx;

  coord_t pix_x, pix_y;
  assign pix_x = coord_t'({2'b00, vid.x});
  assign pix_y = coord_t'({2'b00, vid.y});

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      sh_ball_x    <= '0;
      sh_ball_y    <= '0;
      sh_pad_x     <= '0;
      sh_pad_y     <= '0;
      shadow_valid <= 1'b0;
    end else if (vid.frame_start) begin
      sh_ball_x    <= vid.ball_x;
      sh_ball_y    <= vid.ball_y;
      sh_pad_x     <= vid.paddle_x;
      sh_pad_y     <= vid.paddle_y;
      shadow_valid <= 1'b1;
    end
  end

  always_comb begin
    hit_ball = shadow_valid
            && in_span(pix_x, coord_t'({2'b00, sh_ball_x}), BALL_SIZE)
            && in_span(pix_y, coord_t'({2'b00, sh_ball_y}) - coord_t'(DISP_SHIFT), BALL_SIZE);
    hit_pad = '0;
    for (int i = 0; i < NUM_PADDLES; i++) begin
      hit_pad[i] = shadow_valid
                && in_span(pix_x, coord_t'({2'b00, sh_pad_x[10*i +: 10]}), PADDLE_W)
                && in_span(pix_y, coord_t'({2'b00, sh_pad_y[10*i +: 10]}) - coord_t'(DISP_SHIFT),
                           PADDLE_H);
    end
    dash_row = (MID_DASH == 0) || (((int'(vid.y) / DASH_DIV) % 2) == 0);
    hit_mid  = (int'(vid.x) == MID_LINE_X) && (int'(vid.y) >= MID_Y_LO)
            && (int'(vid.y) < MID_Y_HI) && dash_row;
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      hit_ball_s1 <= 1'b0;
      hit_pad_s1  <= '0;
      hit_mid_s1  <= 1'b0;
      blank_s1    <= 1'b1;
    end else begin
      hit_ball_s1 <= hit_ball;
      hit_pad_s1  <= hit_pad;
      hit_mid_s1  <= hit_mid;
      blank_s1    <= vid.blank;
    end
  end

  assign mid_red = (flash_cnt != '0) && frame_ctr[3];

  always_comb begin
    r_nx = '0;
    g_nx = '0;
    b_nx = '0;
    if (!blank_s1) begin
      if (hit_ball_s1 || (|hit_pad_s1)) begin
        r_nx = '1;
        g_nx = '1;
        b_nx = '1;
      end else if (hit_mid_s1) begin
        r_nx = '1;
        if (!mid_red) begin
          g_nx = '1;
          b_nx = '1;
        end
      end
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      vid.vga_r       <= '0;
      vid.vga_g       <= '0;
      vid.vga_b       <= '0;
      vid.vga_blank_n <= 1'b0;
    end else begin
      vid.vga_r       <= r_nx;
      vid.vga_g       <= g_nx;
      vid.vga_b       <= b_nx;
      vid.vga_blank_n <= ~blank_s1;
    end
  end

  // Overlap is accumulated from stage-1 hits and published at the frame boundary
  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      sticky              <= '0;
      vid.collision       <= '0;
      vid.collision_valid <= 1'b0;
    end else begin
      vid.collision_valid <= vid.frame_start;
      if (vid.frame_start) begin
        vid.collision <= sticky;
        sticky        <= '0;
      end else if (hit_ball_s1 && !blank_s1) begin
        sticky <= sticky | hit_pad_s1;
      end
    end
  end

  always_ff @(posedge clk25 or negedge reset_n) begin
    if (!reset_n) begin
      flash_cnt <= '0;
      frame_ctr <= '0;
    end else begin
      if (vid.frame_start) frame_ctr <= frame_ctr + 4'd1;
      if (vid.point_pulse) begin
        flash_cnt <= FLASH_W'(FLASH_FRAMES);
      end else if (vid.frame_start && (flash_cnt != '0)) begin
        flash_cnt <= flash_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pong_pixel_compositor.sv
// Directed checks of pong_pixel_compositor: rendering, latency, clipping, collision, flash, reset.
module tb_pong_pixel_compositor;

  localparam logic [29:0] WHITE = 30'h3FFF_FFFF;
  localparam logic [29:0] RED   = 30'h3FF0_0000;
  localparam logic [29:0] BLACK = 30'h0;

  logic clk25 = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_err    = 0;
  int   frames   = 0;

  always #20 clk25 = ~clk25;

  pong_pixel_compositor_if #(.NUM_PADDLES(2), .COLOR_W(10)) va ();
  pong_pixel_compositor_if #(.NUM_PADDLES(4), .COLOR_W(10)) vb ();

  assign vb.x           = va.x;
  assign vb.y           = va.y;
  assign vb.blank       = va.blank;
  assign vb.frame_start = va.frame_start;
  assign vb.point_pulse = va.point_pulse;
  assign vb.ball_x      = va.ball_x;
  assign vb.ball_y      = va.ball_y;

  pong_pixel_compositor #(.NUM_PADDLES(2)) dut_a (.clk25(clk25), .reset_n(reset_n), .vid(va));
  pong_pixel_compositor #(.NUM_PADDLES(4)) dut_b (.clk25(clk25), .reset_n(reset_n), .vid(vb));

  logic [29:0] rgb_a, rgb_b;
  assign rgb_a = {va.vga_r, va.vga_g, va.vga_b};
  assign rgb_b = {vb.vga_r, vb.vga_g, vb.vga_b};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Present one pixel and wait until its result is at the outputs
  task automatic pix(input int px, input int py, input logic bl);
    @(negedge clk25);
    va.x     = 10'(px);
    va.y     = 10'(py);
    va.blank = bl;
    @(negedge clk25);
    @(negedge clk25);
  endtask

  task automatic cpa(input string tag, input int px, input int py, input logic [29:0] exp_v);
    pix(px, py, 1'b0);
    check(tag, rgb_a, exp_v);
  endtask

  task automatic cpb(input string tag, input int px, input int py, input logic [29:0] exp_v);
    pix(px, py, 1'b0);
    check(tag, rgb_b, exp_v);
  endtask

  task automatic frame(input logic pp);
    @(negedge clk25);
    va.blank       = 1'b1;
    va.frame_start = 1'b1;
    va.point_pulse = pp;
    @(negedge clk25);
    va.frame_start = 1'b0;
    va.point_pulse = 1'b0;
    frames++;
  endtask

  initial begin
    reset_n        = 1'b1;
    va.x           = '0;
    va.y           = '0;
    va.blank       = 1'b1;
    va.frame_start = 1'b0;
    va.point_pulse = 1'b0;
    va.ball_x      = 10'd100;
    va.ball_y      = 10'd150;
    va.paddle_x    = {10'd1000, 10'd1000};
    va.paddle_y    = {10'd300, 10'd300};
    vb.paddle_x    = {4{10'd1000}};
    vb.paddle_y    = {4{10'd300}};
    #1 reset_n = 1'b0;

    // Reset state
    @(negedge clk25);
    check("rst_rgb", rgb_a, BLACK);
    check("rst_blank_n", va.vga_blank_n, 1'b0);
    check("rst_coll", va.collision, 2'b00);
    check("rst_coll_vld", va.collision_valid, 1'b0);
    reset_n = 1'b1;

    // Before the first snapshot only the midline is drawn
    cpa("pre_ball_hidden", 100, 100, BLACK);
    cpa("mid_y20", 325, 20, WHITE);
    cpa("mid_dash_y10", 325, 10, BLACK);
    cpa("mid_y_lo", 325, 5, WHITE);
    cpa("mid_y_lo_m1", 325, 4, BLACK);
    cpa("mid_y_hi_m1", 325, 469, WHITE);
    cpa("mid_y_hi", 325, 470, BLACK);
    cpa("mid_x_m1", 324, 20, BLACK);
    cpa("mid_x_p1", 326, 20, BLACK);

    // Ball only at (100,150) -> screen (100,100)
    frame(1'b0);
    check("f1_coll_vld", va.collision_valid, 1'b1);
    check("f1_coll", va.collision, 2'b00);
    @(negedge clk25);
    check("f1_coll_vld_drop", va.collision_valid, 1'b0);
    cpa("ball_tl", 100, 100, WHITE);
    cpa("ball_br", 104, 104, WHITE);
    cpa("ball_right", 105, 100, BLACK);
    cpa("ball_left", 99, 100, BLACK);
    cpa("ball_below", 100, 105, BLACK);
    cpa("ball_above", 100, 99, BLACK);
    check("blank_n_active", va.vga_blank_n, 1'b1);
    pix(102, 102, 1'b1);
    check("blank_rgb", rgb_a, BLACK);
    check("blank_n_blank", va.vga_blank_n, 1'b0);

    // Exact 2-cycle latency
    pix(0, 0, 1'b0);
    @(negedge clk25);
    va.x = 10'd102; va.y = 10'd102;
    @(negedge clk25);
    check("lat_1cyc", rgb_a, BLACK);
    va.x = 10'd0; va.y = 10'd0;
    @(negedge clk25);
    check("lat_2cyc", rgb_a, WHITE);
    @(negedge clk25);
    check("lat_3cyc", rgb_a, BLACK);

    // No tearing: ball_x change waits for the next frame_start
    va.ball_x = 10'd200;
    cpa("tear_old_pos", 100, 100, WHITE);
    cpa("tear_new_pos", 200, 100, BLACK);
    frame(1'b0);
    cpa("moved_new_pos", 200, 100, WHITE);
    cpa("moved_old_pos", 100, 100, BLACK);

    // Clipping: ball sy=-30, paddle0 sy=-20, paddle1 x 1020..1029
    va.ball_y   = 10'd20;
    va.paddle_x = {10'd1020, 10'd500};
    va.paddle_y = {10'd300, 10'd30};
    frame(1'b0);
    cpa("clip_ball_top", 200, 0, BLACK);
    cpa("clip_ball_nowrap", 200, 996, BLACK);
    cpa("clip_pad_row0", 500, 0, WHITE);
    cpa("clip_pad_row79", 509, 79, WHITE);
    cpa("clip_pad_row80", 500, 80, BLACK);
    cpa("clip_pad_x510", 510, 0, BLACK);
    cpa("clip_right_edge", 1023, 260, WHITE);
    cpa("clip_right_nowrap", 2, 260, BLACK);

    // Collision: paddle1 (630,250), ball (632,290)
    va.paddle_x = {10'd630, 10'd500};
    va.paddle_y = {10'd250, 10'd30};
    va.ball_x   = 10'd632;
    va.ball_y   = 10'd290;
    frame(1'b0);
    check("f4_coll", va.collision, 2'b00);
    cpa("coll_ball_over_pad", 634, 242, WHITE);
    cpa("coll_pad1_corner", 630, 200, WHITE);
    va.ball_x = 10'd100;
    va.ball_y = 10'd150;
    frame(1'b0);
    check("f5_coll_vld", va.collision_valid, 1'b1);
    check("f5_coll", va.collision, 2'b10);
    @(negedge clk25);
    check("f5_coll_vld_drop", va.collision_valid, 1'b0);
    check("f5_coll_hold", va.collision, 2'b10);
    cpa("f5_ball_moved", 100, 100, WHITE);
    va.ball_x = 10'd632;
    va.ball_y = 10'd290;
    frame(1'b0);
    check("f6_coll_clear", va.collision, 2'b00);
    pix(634, 242, 1'b1);
    frame(1'b0);
    check("f7_coll_blank_ignored", va.collision, 2'b00);

    // Flash: point with frame_start at frame_ctr 16; ends at 76
    while (frames < 15) frame(1'b0);
    frame(1'b1);
    cpa("flash_ctr16_white", 325, 20, WHITE);
    cpa("flash_dash_dark", 325, 10, BLACK);
    while (frames < 24) frame(1'b0);
    cpa("flash_ctr24_red", 325, 20, RED);
    cpa("flash_dash_dark_red", 325, 12, BLACK);
    while (frames < 75) frame(1'b0);
    cpa("flash_ctr75_red", 325, 20, RED);
    frame(1'b0);
    cpa("flash_ctr76_white", 325, 20, WHITE);

    // Asynchronous reset mid-line
    cpa("pre_rst_ball", 634, 242, WHITE);
    @(negedge clk25);
    va.blank = 1'b0;
    #5 reset_n = 1'b0;
    #1;
    check("async_rst_rgb", rgb_a, BLACK);
    check("async_rst_blank_n", va.vga_blank_n, 1'b0);
    @(negedge clk25);
    reset_n = 1'b1;
    frames  = 0;
    cpa("post_rst_no_ball", 634, 242, BLACK);
    cpa("post_rst_mid", 325, 20, WHITE);
    frame(1'b0);
    cpa("post_rst_ball_back", 634, 242, WHITE);

    // Four paddles: p0 (300,150), p1 off, p2 (400,350), p3 (305,150) overlapping p0
    vb.paddle_x = {10'd305, 10'd400, 10'd1000, 10'd300};
    vb.paddle_y = {10'd150, 10'd350, 10'd300, 10'd150};
    va.ball_x   = 10'd312;
    va.ball_y   = 10'd160;
    frame(1'b0);
    cpb("p4_ball", 312, 110, WHITE);
    cpb("p4_pad3_only", 312, 120, WHITE);
    cpb("p4_pad0_only", 302, 120, WHITE);
    cpb("p4_pad0_pad3", 305, 100, WHITE);
    cpb("p4_pad2", 400, 300, WHITE);
    cpb("p4_pad2_right", 410, 300, BLACK);
    cpb("p4_gap", 316, 120, BLACK);
    frame(1'b0);
    check("p4_coll_vld", vb.collision_valid, 1'b1);
    check("p4_coll", vb.collision, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
